// File: rtl/cordic_pkg.sv
// Shared definitions for the folded CORDIC rotation engine.
//   - FSM state encoding used by cordic_rotation_sequencer
//   - n64q60 angle constants (pi, pi/2 and their negatives); these are the
//     n54q50 constants zero-extended by 10 fractional bits
//   - 31-entry atan(2^-i) table and cumulative CORDIC gain table, both n64q60
//     with n54q50 precision (low 10 bits zero)
package cordic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_ITER = 3'd2,
    ST_POST = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  localparam int TABLE_DEPTH = 31;
  localparam int TABLE_Q     = 60;

  localparam logic [63:0] PI_Q60          = 64'h3243_F6A8_885A_3000;
  localparam logic [63:0] HALF_PI_Q60     = 64'h1921_FB54_442D_1800;
  localparam logic [63:0] NEG_PI_Q60      = 64'hCDBC_0957_77A5_D000;
  localparam logic [63:0] NEG_HALF_PI_Q60 = 64'hE6DE_04AB_BBD2_E800;

  // Round a real to n54q50 and widen it to n64q60 by appending 10 zero bits.
  function automatic logic [63:0] q50_to_q60(input real value);
    logic [63:0] q50_bits;
    q50_bits = 64'(longint'(value * 1125899906842624.0));
    return q50_bits << 10;
  endfunction

  // atan(2^-i); from i=17 on, atan(2^-i) rounds to 2^-i at q50 precision.
  localparam logic [63:0] ATAN_TABLE [TABLE_DEPTH] = '{
    q50_to_q60(0.78539816339744830962), q50_to_q60(0.46364760900080611621),
    q50_to_q60(0.24497866312686415417), q50_to_q60(0.12435499454676143503),
    q50_to_q60(0.06241880999595734847), q50_to_q60(0.03123983343026827625),
    q50_to_q60(0.01562372862047683080), q50_to_q60(0.00781234106010111129),
    q50_to_q60(0.00390623013196697182), q50_to_q60(0.00195312251647881868),
    q50_to_q60(0.00097656218955931943), q50_to_q60(0.00048828121119489827),
    q50_to_q60(0.00024414062014936177), q50_to_q60(0.00012207031189367021),
    q50_to_q60(0.00006103515617420877), q50_to_q60(0.00003051757811552610),
    q50_to_q60(0.00001525878906131576), q50_to_q60(1.0 / 131072.0),
    q50_to_q60(1.0 / 262144.0),         q50_to_q60(1.0 / 524288.0),
    q50_to_q60(1.0 / 1048576.0),        q50_to_q60(1.0 / 2097152.0),
    q50_to_q60(1.0 / 4194304.0),        q50_to_q60(1.0 / 8388608.0),
    q50_to_q60(1.0 / 16777216.0),       q50_to_q60(1.0 / 33554432.0),
    q50_to_q60(1.0 / 67108864.0),       q50_to_q60(1.0 / 134217728.0),
    q50_to_q60(1.0 / 268435456.0),      q50_to_q60(1.0 / 536870912.0),
    q50_to_q60(1.0 / 1073741824.0)
  };

  // gain[k] = prod_{j=0..k} 1/sqrt(1 + 2^-2j): start value for k+1 iterations.
  localparam logic [63:0] GAIN_TABLE [TABLE_DEPTH] = '{
    q50_to_q60(0.70710678118654752), q50_to_q60(0.63245553203367587),
    q50_to_q60(0.61357199107789634), q50_to_q60(0.60883391251775243),
    q50_to_q60(0.60764825625616820), q50_to_q60(0.60735177014129595),
    q50_to_q60(0.60727764409352600), q50_to_q60(0.60725911229889273),
    q50_to_q60(0.60725447933256233), q50_to_q60(0.60725332108987518),
    q50_to_q60(0.60725303152913433), q50_to_q60(0.60725295913894484),
    q50_to_q60(0.60725294104139716), q50_to_q60(0.60725293651701024),
    q50_to_q60(0.60725293538591351), q50_to_q60(0.60725293510313934),
    q50_to_q60(0.60725293503244580), q50_to_q60(0.60725293501477242),
    q50_to_q60(0.60725293501035407), q50_to_q60(0.60725293500924948),
    q50_to_q60(0.60725293500897333), q50_to_q60(0.60725293500890429),
    q50_to_q60(0.60725293500888703), q50_to_q60(0.60725293500888126),
    q50_to_q60(0.60725293500888126), q50_to_q60(0.60725293500888126),
    q50_to_q60(0.60725293500888126), q50_to_q60(0.60725293500888126),
    q50_to_q60(0.60725293500888126), q50_to_q60(0.60725293500888126),
    q50_to_q60(0.60725293500888126)
  };

endpackage

// File: rtl/cordic_rotation_stage.sv
// One combinational CORDIC rotation-mode micro-rotation.
// Ports:
//   x, y, z   current vector and residual angle (signed fixed point)
//   shift     iteration index i, used as the arithmetic shift distance
//   atan      atan(2^-i) in the same fixed-point format as z
//   x_next, y_next, z_next   rotated vector and updated residual angle
// Shifts sign-extend and truncate; adds wrap at N_BITS_P with no saturation.
module cordic_rotation_stage #(
  parameter int N_BITS_P  = 64,
  parameter int SHIFT_W_P = 5
) (
  input  logic signed [N_BITS_P-1:0]  x,
  input  logic signed [N_BITS_P-1:0]  y,
  input  logic signed [N_BITS_P-1:0]  z,
  input  logic        [SHIFT_W_P-1:0] shift,
  input  logic signed [N_BITS_P-1:0]  atan,
  output logic signed [N_BITS_P-1:0]  x_next,
  output logic signed [N_BITS_P-1:0]  y_next,
  output logic signed [N_BITS_P-1:0]  z_next
);

  logic signed [N_BITS_P-1:0] x_sh_s;
  logic signed [N_BITS_P-1:0] y_sh_s;

  // Rotate towards z = 0: d = +1 when z >= 0, otherwise d = -1.
  always_comb begin
    x_sh_s = x >>> shift;
    y_sh_s = y >>> shift;
    if (z[N_BITS_P-1] == 1'b0) begin
      x_next = x - y_sh_s;
      y_next = y + x_sh_s;
      z_next = z - atan;
    end else begin
      x_next = x + y_sh_s;
      y_next = y - x_sh_s;
      z_next = z + atan;
    end
  end

endmodule

// File: rtl/cordic_rotation_sequencer.sv
// Folded CORDIC engine, rotation mode: cos/sin of an angle in radians.
// One shared rotation stage is stepped NR_OF_STAGES_P times, framed by a
// clamp + quadrant-fold cycle (PRE) and a sign-restore cycle (POST).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ing_valid/ready angle input handshake; ready only while idle
//   ing_theta       angle, signed fixed point (default n64q60)
//   egr_valid/ready result handshake; result held until accepted
//   egr_cosine      cos(theta), egr_sine sin(theta)
//   egr_range_err   theta was outside [-pi, pi] and clamped
// The package tables are n64q60; they are rescaled to Q_BITS_P by an
// arithmetic right shift, so Q_BITS_P must not exceed 60.
module cordic_rotation_sequencer
  import cordic_pkg::*;
#(
  parameter int N_BITS_P       = 64,
  parameter int Q_BITS_P       = 60,
  parameter int NR_OF_STAGES_P = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ing_valid,
  output logic                ing_ready,
  input  logic [N_BITS_P-1:0] ing_theta,
  output logic                egr_valid,
  input  logic                egr_ready,
  output logic [N_BITS_P-1:0] egr_cosine,
  output logic [N_BITS_P-1:0] egr_sine,
  output logic                egr_range_err
);

  localparam int          TABLE_SHIFT = TABLE_Q - Q_BITS_P;
  localparam logic [4:0]  LAST_ITER   = 5'(NR_OF_STAGES_P - 1);

  // Bring an n64q60 table constant into the engine's number format.
  function automatic logic signed [N_BITS_P-1:0] rescale(input logic [63:0] value);
    logic signed [63:0] v_s;
    v_s = value;
    return N_BITS_P'(v_s >>> TABLE_SHIFT);
  endfunction

  localparam logic signed [N_BITS_P-1:0] PI_C          = rescale(PI_Q60);
  localparam logic signed [N_BITS_P-1:0] HALF_PI_C     = rescale(HALF_PI_Q60);
  localparam logic signed [N_BITS_P-1:0] NEG_PI_C      = rescale(NEG_PI_Q60);
  localparam logic signed [N_BITS_P-1:0] NEG_HALF_PI_C = rescale(NEG_HALF_PI_Q60);
  localparam logic signed [N_BITS_P-1:0] GAIN_C        = rescale(GAIN_TABLE[NR_OF_STAGES_P-1]);

  state_t state_r;
  state_t state_next_s;

  logic                       ing_ready_r;
  logic                       ing_ready_next_s;
  logic                       egr_valid_r;
  logic                       egr_valid_next_s;

  logic signed [N_BITS_P-1:0] theta_r;
  logic signed [N_BITS_P-1:0] x_r;
  logic signed [N_BITS_P-1:0] y_r;
  logic signed [N_BITS_P-1:0] z_r;
  logic [4:0]                 iter_r;
  logic                       flip_r;
  logic                       range_r;
  logic signed [N_BITS_P-1:0] cosine_r;
  logic signed [N_BITS_P-1:0] sine_r;
  logic                       range_err_r;

  logic signed [N_BITS_P-1:0] clamped_s;
  logic                       out_of_range_s;
  logic signed [N_BITS_P-1:0] z_fold_s;
  logic                       flip_s;
  logic signed [N_BITS_P-1:0] atan_s;
  logic signed [N_BITS_P-1:0] x_next_s;
  logic signed [N_BITS_P-1:0] y_next_s;
  logic signed [N_BITS_P-1:0] z_next_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic. Acceptance is gated by the registered ready so an
  // angle is never taken in the cycle where ready still shows its reset 0.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ing_valid && ing_ready_r) begin
          state_next_s = ST_PRE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PRE:  state_next_s = ST_ITER;
      ST_ITER: begin
        if (iter_r == LAST_ITER) begin
          state_next_s = ST_POST;
        end else begin
          state_next_s = ST_ITER;
        end
      end
      ST_POST: state_next_s = ST_OUT;
      ST_OUT: begin
        if (egr_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_OUT;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs, computed one cycle ahead so the handshake flags are flops.
  always_comb begin
    ing_ready_next_s = (state_next_s == ST_IDLE);
    egr_valid_next_s = (state_next_s == ST_OUT);
  end

  // Handshake flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ing_ready_r <= 1'b0;
      egr_valid_r <= 1'b0;
    end else begin
      ing_ready_r <= ing_ready_next_s;
      egr_valid_r <= egr_valid_next_s;
    end
  end

  // Clamp to [-pi, pi], then fold the outer quadrants onto [-pi/2, pi/2];
  // the folded result is the negated rotation, restored in POST.
  always_comb begin
    if (theta_r > PI_C) begin
      clamped_s      = PI_C;
      out_of_range_s = 1'b1;
    end else if (theta_r < NEG_PI_C) begin
      clamped_s      = NEG_PI_C;
      out_of_range_s = 1'b1;
    end else begin
      clamped_s      = theta_r;
      out_of_range_s = 1'b0;
    end
    if (clamped_s > HALF_PI_C) begin
      z_fold_s = clamped_s - PI_C;
      flip_s   = 1'b1;
    end else if (clamped_s < NEG_HALF_PI_C) begin
      z_fold_s = clamped_s + PI_C;
      flip_s   = 1'b1;
    end else begin
      z_fold_s = clamped_s;
      flip_s   = 1'b0;
    end
  end

  // Table lookup for the current iteration.
  always_comb begin
    atan_s = rescale(ATAN_TABLE[iter_r]);
  end

  cordic_rotation_stage #(
    .N_BITS_P  (N_BITS_P),
    .SHIFT_W_P (5)
  ) u_stage (
    .x      (x_r),
    .y      (y_r),
    .z      (z_r),
    .shift  (iter_r),
    .atan   (atan_s),
    .x_next (x_next_s),
    .y_next (y_next_s),
    .z_next (z_next_s)
  );

  // Datapath: angle capture, pre-rotation load, iteration, result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      theta_r     <= '0;
      x_r         <= '0;
      y_r         <= '0;
      z_r         <= '0;
      iter_r      <= 5'd0;
      flip_r      <= 1'b0;
      range_r     <= 1'b0;
      cosine_r    <= '0;
      sine_r      <= '0;
      range_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ing_valid && ing_ready_r) begin
            theta_r <= ing_theta;
          end
        end
        ST_PRE: begin
          x_r     <= GAIN_C;
          y_r     <= '0;
          z_r     <= z_fold_s;
          iter_r  <= 5'd0;
          flip_r  <= flip_s;
          range_r <= out_of_range_s;
        end
        ST_ITER: begin
          x_r    <= x_next_s;
          y_r    <= y_next_s;
          z_r    <= z_next_s;
          iter_r <= iter_r + 5'd1;
        end
        ST_POST: begin
          cosine_r    <= flip_r ? -x_r : x_r;
          sine_r      <= flip_r ? -y_r : y_r;
          range_err_r <= range_r;
        end
        default: begin
          // ST_OUT: result registers hold until the downstream handshake.
        end
      endcase
    end
  end

  assign ing_ready     = ing_ready_r;
  assign egr_valid     = egr_valid_r;
  assign egr_cosine    = cosine_r;
  assign egr_sine      = sine_r;
  assign egr_range_err = range_err_r;

endmodule

// File: tb/tb_cordic_rotation_sequencer.sv
// Self-checking bench for cordic_rotation_sequencer (default n64q60, 16 stages).
// Expected values come from $cos/$sin of the clamped angle, queued when an
// angle is driven and popped when the engine presents its result.
module tb_cordic_rotation_sequencer;

  localparam int     NS    = 16;
  localparam real    SCALE = 1152921504606846976.0;
  localparam real    TOL   = 1.0 / 16384.0;
  localparam real    PI_R  = 3.14159265358979323846;
  localparam longint PI_Q  = 64'sh3243_F6A8_885A_3000;
  localparam longint HPI_Q = 64'sh1921_FB54_442D_1800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ing_valid = 1'b0;
  logic        ing_ready;
  logic [63:0] ing_theta = 64'd0;
  logic        egr_valid;
  logic        egr_ready = 1'b0;
  logic [63:0] egr_cosine;
  logic [63:0] egr_sine;
  logic        egr_range_err;

  typedef struct {
    longint theta;
    real    cos_e;
    real    sin_e;
    bit     err_e;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [63:0] pi_cos;
  logic [63:0] pi_sin;

  always #5 clk = ~clk;

  cordic_rotation_sequencer #(
    .N_BITS_P       (64),
    .Q_BITS_P       (60),
    .NR_OF_STAGES_P (NS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ing_valid     (ing_valid),
    .ing_ready     (ing_ready),
    .ing_theta     (ing_theta),
    .egr_valid     (egr_valid),
    .egr_ready     (egr_ready),
    .egr_cosine    (egr_cosine),
    .egr_sine      (egr_sine),
    .egr_range_err (egr_range_err)
  );

  function automatic real q_to_r(input logic [63:0] v);
    longint s;
    s = v;
    return real'(s) / SCALE;
  endfunction

  function automatic longint r_to_q(input real r);
    return longint'(r * SCALE);
  endfunction

  function automatic bit near(input real a, input real b);
    return ((a - b) < TOL) && ((b - a) < TOL);
  endfunction

  // Reference model: clamp to [-pi, pi], then exact trig.
  function automatic exp_t make_exp(input longint theta);
    exp_t   e;
    longint c;
    c = theta;
    e.err_e = 1'b0;
    if (theta > PI_Q) begin
      c = PI_Q;
      e.err_e = 1'b1;
    end else if (theta < -PI_Q) begin
      c = -PI_Q;
      e.err_e = 1'b1;
    end
    e.theta = theta;
    e.cos_e = $cos(q_to_r(c));
    e.sin_e = $sin(q_to_r(c));
    return e;
  endfunction

  task automatic send_angle(input longint theta);
    int k;
    k = 0;
    while (ing_ready !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    tests_run++;
    if (ing_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL send_ready: ing_ready=%b required 1", ing_ready);
    end
    ing_valid = 1'b1;
    ing_theta = theta;
    sb.push_back(make_exp(theta));
    @(posedge clk); #1;
    ing_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (egr_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack();
    egr_ready = 1'b1;
    @(posedge clk); #1;
    egr_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({ing_ready, egr_valid, egr_range_err} !== 3'b000 || egr_cosine !== 64'd0 || egr_sine !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_values: rdy=%b vld=%b err=%b cos=%h sin=%h required all 0",
               ing_ready, egr_valid, egr_range_err, egr_cosine, egr_sine);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (ing_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: ing_ready=%b required 1", ing_ready);
    end
  endtask

  task automatic test_zero();
    int   lat;
    exp_t e;
    send_angle(64'sd0);
    wait_valid(lat);
    e = sb.pop_front();
    tests_run++;
    if (lat !== NS + 2) begin
      tests_failed++;
      $display("FAIL zero_latency: got %0d cycles required %0d", lat, NS + 2);
    end
    tests_run++;
    if (!near(q_to_r(egr_cosine), 1.0) || !near(q_to_r(egr_sine), 0.0) || egr_range_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_value: cos=%f sin=%f err=%b required 1.0 0.0 0", q_to_r(egr_cosine),
               q_to_r(egr_sine), egr_range_err);
    end
    ack();
  endtask

  task automatic test_fold_boundaries();
    longint angles[6];
    int     lat;
    exp_t   e;
    angles = '{HPI_Q, -HPI_Q, r_to_q(0.75 * PI_R), r_to_q(-0.75 * PI_R), PI_Q, -PI_Q};
    foreach (angles[i]) begin
      send_angle(angles[i]);
      wait_valid(lat);
      e = sb.pop_front();
      tests_run++;
      if (lat !== NS + 2) begin
        tests_failed++;
        $display("FAIL fold_latency[%0d]: got %0d cycles required %0d", i, lat, NS + 2);
      end
      tests_run++;
      if (!near(q_to_r(egr_cosine), e.cos_e) || !near(q_to_r(egr_sine), e.sin_e) || egr_range_err !== e.err_e) begin
        tests_failed++;
        $display("FAIL fold_value[%0d]: cos=%f sin=%f err=%b required %f %f %b", i,
                 q_to_r(egr_cosine), q_to_r(egr_sine), egr_range_err, e.cos_e, e.sin_e, e.err_e);
      end
      if (i == 4) begin
        pi_cos = egr_cosine;
        pi_sin = egr_sine;
      end
      ack();
    end
  endtask

  task automatic test_range();
    longint angles[2];
    int     lat;
    exp_t   e;
    angles = '{r_to_q(4.0), r_to_q(1.0)};
    foreach (angles[i]) begin
      send_angle(angles[i]);
      wait_valid(lat);
      e = sb.pop_front();
      tests_run++;
      if (egr_range_err !== e.err_e) begin
        tests_failed++;
        $display("FAIL range_flag[%0d]: err=%b required %b", i, egr_range_err, e.err_e);
      end
      tests_run++;
      if (!near(q_to_r(egr_cosine), e.cos_e) || !near(q_to_r(egr_sine), e.sin_e)) begin
        tests_failed++;
        $display("FAIL range_value[%0d]: cos=%f sin=%f required %f %f", i,
                 q_to_r(egr_cosine), q_to_r(egr_sine), e.cos_e, e.sin_e);
      end
      if (i == 0) begin
        tests_run++;
        if (egr_cosine !== pi_cos || egr_sine !== pi_sin) begin
          tests_failed++;
          $display("FAIL range_equals_pi: cos=%h sin=%h required %h %h", egr_cosine, egr_sine,
                   pi_cos, pi_sin);
        end
      end
      ack();
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    exp_t        e;
    logic [63:0] c0;
    logic [63:0] s0;
    logic        r0;
    send_angle(r_to_q(0.3));
    wait_valid(lat);
    e = sb.pop_front();
    tests_run++;
    if (!near(q_to_r(egr_cosine), e.cos_e) || !near(q_to_r(egr_sine), e.sin_e) || egr_range_err !== e.err_e) begin
      tests_failed++;
      $display("FAIL bp_value: cos=%f sin=%f err=%b required %f %f %b", q_to_r(egr_cosine),
               q_to_r(egr_sine), egr_range_err, e.cos_e, e.sin_e, e.err_e);
    end
    c0 = egr_cosine;
    s0 = egr_sine;
    r0 = egr_range_err;
    // Offer the next angle while stalled; it must wait until the engine idles.
    ing_valid = 1'b1;
    ing_theta = r_to_q(-2.0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (egr_valid !== 1'b1 || ing_ready !== 1'b0 || egr_cosine !== c0 || egr_sine !== s0 || egr_range_err !== r0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b cos=%h sin=%h err=%b required 1 0 %h %h %b", k,
                 egr_valid, ing_ready, egr_cosine, egr_sine, egr_range_err, c0, s0, r0);
      end
    end
    egr_ready = 1'b1;
    @(posedge clk); #1;
    egr_ready = 1'b0;
    tests_run++;
    if (ing_ready !== 1'b1 || egr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: rdy=%b vld=%b required 1 0", ing_ready, egr_valid);
    end
    sb.push_back(make_exp(r_to_q(-2.0)));
    @(posedge clk); #1;
    ing_valid = 1'b0;
    wait_valid(lat);
    e = sb.pop_front();
    tests_run++;
    if (lat !== NS + 2) begin
      tests_failed++;
      $display("FAIL b2b_latency: got %0d cycles required %0d", lat, NS + 2);
    end
    tests_run++;
    if (!near(q_to_r(egr_cosine), e.cos_e) || !near(q_to_r(egr_sine), e.sin_e) || egr_range_err !== e.err_e) begin
      tests_failed++;
      $display("FAIL b2b_value: cos=%f sin=%f err=%b required %f %f %b", q_to_r(egr_cosine),
               q_to_r(egr_sine), egr_range_err, e.cos_e, e.sin_e, e.err_e);
    end
    ack();
  endtask

  task automatic test_reset_mid_op();
    int   lat;
    exp_t e;
    bit   seen_valid;
    send_angle(r_to_q(2.5));
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete(sb.size() - 1);
    tests_run++;
    if ({ing_ready, egr_valid, egr_range_err} !== 3'b000 || egr_cosine !== 64'd0 || egr_sine !== 64'd0) begin
      tests_failed++;
      $display("FAIL midrst_values: rdy=%b vld=%b err=%b cos=%h sin=%h required all 0",
               ing_ready, egr_valid, egr_range_err, egr_cosine, egr_sine);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (ing_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_ready: ing_ready=%b required 1", ing_ready);
    end
    seen_valid = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (egr_valid !== 1'b0) seen_valid = 1'b1;
      @(posedge clk); #1;
    end
    tests_run++;
    if (seen_valid) begin
      tests_failed++;
      $display("FAIL midrst_no_pulse: egr_valid seen=1 required 0");
    end
    send_angle(r_to_q(0.5));
    wait_valid(lat);
    e = sb.pop_front();
    tests_run++;
    if (lat !== NS + 2 || !near(q_to_r(egr_cosine), e.cos_e) || !near(q_to_r(egr_sine), e.sin_e)) begin
      tests_failed++;
      $display("FAIL midrst_recover: lat=%0d cos=%f sin=%f required %0d %f %f", lat,
               q_to_r(egr_cosine), q_to_r(egr_sine), NS + 2, e.cos_e, e.sin_e);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_fold_boundaries();
    test_range();
    test_backpressure();
    test_reset_mid_op();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_empty: %0d entries left required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cordic_rotation_sequencer.md
Name: cordic_rotation_sequencer

Overview:
Iterative (folded) CORDIC engine in rotation mode. It computes sine and cosine of an input angle in radians. One shared shift/add/subtract stage is sequenced over NR_OF_STAGES_P cycles. A quadrant pre-rotation, the atan table lookup and gain pre-scaling are applied around that loop. It sits in the math library as the area-optimised alternative to a fully unrolled CORDIC pipeline, behind a valid/ready stream interface.

Parameters:
N_BITS_P, 64, data width of angle and results (signed fixed point)
Q_BITS_P, 60, fractional bits (n64q60)
NR_OF_STAGES_P, 16, CORDIC iterations, legal range 1..31

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
ing_valid  input  1  angle valid
ing_ready  output  1  engine idle and able to accept an angle
ing_theta  input  N_BITS_P  angle in radians, signed n64q60
egr_valid  output  1  result valid
egr_ready  input  1  downstream accepts result
egr_cosine  output  N_BITS_P  cos(theta), n64q60
egr_sine  output  N_BITS_P  sin(theta), n64q60
egr_range_err  output  1  theta was outside [-pi, pi] and was clamped; qualified by egr_valid

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: ing_ready=0 during reset and 1 in the first cycle after reset; egr_valid=0; egr_cosine=0; egr_sine=0; egr_range_err=0; FSM=IDLE.
- FSM states and transitions:
  - IDLE: ing_ready=1. On ing_valid go to PRE.
  - PRE: one cycle. Clamp theta to [-pi, pi] and set the range flag. Then quadrant fold:
    - theta > pi/2: z=theta-pi, flip=1
    - theta < -pi/2: z=theta+pi, flip=1
    - otherwise: z=theta, flip=0
    - Load x=gain_table[NR_OF_STAGES_P-1], y=0, i=0. Go to ITER.
  - ITER: one iteration per cycle, i from 0 to NR_OF_STAGES_P-1.
    - d=+1 if z>=0, else -1.
    - x'=x-d*(y>>>i); y'=y+d*(x>>>i); z'=z-d*atan_table[i].
    - Shifts are arithmetic (sign-extending) and truncate; no rounding. All adds are N_BITS_P wide, wrapping with no saturation. For |theta|<=pi, intermediates stay below 2.0, so no overflow occurs.
    - After iteration NR_OF_STAGES_P-1, go to POST.
  - POST: one cycle. Register cos=flip?-x:x and sin=flip?-y:y. Go to OUT.
  - OUT: egr_valid=1. Outputs are held stable until egr_ready=1; on that handshake go to IDLE.
- Handshakes:
  - ing_ready is 1 only in IDLE; no new angle is accepted while busy.
  - ing_theta is sampled on the ing_valid && ing_ready edge only.
- Latency: angle accept to egr_valid high = NR_OF_STAGES_P+2 cycles (PRE + ITER + POST). Minimum spacing between accepts = NR_OF_STAGES_P+4 cycles.
- Backpressure: egr_valid stays high and egr_cosine/egr_sine/egr_range_err stay constant while egr_ready=0. egr_valid never deasserts without a handshake.
- Boundaries:
  - theta = exactly +pi/2 or -pi/2: not folded (flip=0).
  - theta = exactly +pi or -pi: folded, z=0.
- Reset mid-operation (any state): abort immediately, return to the reset values. The in-flight result is discarded, with no egr_valid pulse.
- egr_ready while not in OUT: ignored.

Decomposition:
- Shared package cordic_pkg holds:
  - FSM state enum.
  - n64q60 constants pi, pi/2, -pi, -pi/2, derived as the existing n54q50 constants concatenated with 10'b0.
  - The 31-entry atan table and gain table (n64q60).
- Natural sub-module: cordic_rotation_stage. It is a combinational single iteration: inputs x, y, z, shift index, atan value; outputs x', y', z'. The FSM, counter and registers remain in the top.

Test Plan:
- theta=0 -> cos=1.0 (0x1000_0000_0000_0000), sin=0, each within 2^-14 (NR_OF_STAGES_P=16). egr_valid asserts exactly 18 cycles after accept; egr_range_err=0.
- theta=pi/2 and theta=-pi/2 -> cos≈0, sin≈+1.0 and -1.0 respectively, within 2^-14; flip=0 path.
- theta=3pi/4 and theta=-3pi/4 -> cos≈-0.707107, sin≈+0.707107 and -0.707107 respectively. theta=+pi -> cos≈-1.0, sin≈0. All exercise the fold path.
- theta=4.0 rad -> egr_range_err=1, result equals that of theta=pi. Next op with theta=1.0 -> egr_range_err=0, cos≈0.540302, sin≈0.841471.
- Backpressure: hold egr_ready=0 for 10 cycles in OUT -> egr_valid stays 1, outputs bit-stable, ing_ready=0. Raise egr_ready -> ing_ready=1 next cycle. Back-to-back ing_valid is accepted only then.
- Assert rst at iteration 5 -> next cycle all outputs at reset values, no egr_valid pulse. New op with theta=0.5 completes correctly: cos≈0.877583, sin≈0.479426.
